mult_pp_issue_8: RTL and testbench
==================================

Name: mult_pp_issue_8

Overview:
- Upstream feeder for the carry-save accumulator (carry_save_8) in the 8-bit multiplier execution unit.
- Accepts 32-bit vector operands A and B plus an element width (sew) over a valid/ready handshake.
- Splits the operands into bytes and forms unsigned 8x8 partial products, eight per cycle.
- Issues the products on mult_out_1..8 with start/sew in the beat order the accumulator expects: one beat for 8/16-bit, two beats for 32-bit.

Parameters:
- none (datapath fixed at 32-bit operands, 8-bit slices, 8 product lanes of 16 bits)

Ports:
- clk  in  1  clock; all registers update on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- sew  in  2  element width: 00=8b, 01=16b, 10=32b, 11=illegal
- op_a  in  32  operand A
- op_b  in  32  operand B
- start  out  1  high while a product beat is presented
- sew_out  out  2  latched sew of the beat presented
- last  out  1  high on the final beat of an operation
- mult_out_1..mult_out_8  out  16 each  unsigned byte products, zero-extended to 16 bits

Behaviour:
- Bytes: aN = op_a[8N+7:8N], bN = op_b[8N+7:8N]. All products are unsigned; no sign handling in this block.
- Reset (reset=0, immediate, asynchronous):
  - state=IDLE; start=0, last=0, sew_out=00, all mult_out=0.
  - Any in-flight beat is dropped; nothing is issued after reset deasserts until a new accept.
- FSM states: IDLE, BEAT0, BEAT1. Output registers load on each state transition.
- in_ready (combinational) = (state==IDLE) | (state==BEAT0 & sew_q!=10) | (state==BEAT1).
- Accept = in_valid & in_ready at a rising edge:
  - Latch op_a, op_b, sew.
  - Load beat-0 products; next state BEAT0.
  - Latency: beat 0 is visible the cycle after the accept edge.
- Beat maps:
  - sew=10, beat 0: 1..4 = a0b0,a1b0,a2b0,a3b0; 5..8 = a0b1,a1b1,a2b1,a3b1.
  - sew=10, beat 1: 1..4 = a0b2,a1b2,a2b2,a3b2; 5..8 = a0b3,a1b3,a2b3,a3b3.
  - sew=01, single beat: 1..4 = a0b0,a1b0,a0b1,a1b1; 5..8 = a2b2,a3b2,a2b3,a3b3.
  - sew=00, single beat: 1..4 = a0b0,a1b1,a2b2,a3b3; 5..8 = 0.
  - sew=11, single beat: all zero; start=1, last=1, sew_out=11 (downstream flags the error).
- BEAT0 with sew_q=10:
  - last=0; in_ready=0.
  - Next edge loads beat 1 from the latched operands; next state BEAT1.
- BEAT0 with sew_q!=10, and BEAT1 (final beats):
  - last=1.
  - If accept occurs on this edge, the new op's beat 0 loads and state goes to BEAT0 (back-to-back, no bubble).
  - Otherwise outputs clear to 0, start=0, and state goes to IDLE.
- start=1 in BEAT0/BEAT1 and 0 in IDLE. sew_out holds the latched sew for every beat of the operation.
- Operands/sew changing on the inputs while in BEAT0/BEAT1 have no effect on the current operation (latched copies are used).
- Throughput:
  - 8/16-bit: one op per cycle.
  - 32-bit: one op per 2 cycles.

Test Plan:
- Reset value check: hold reset=0 -> in_ready=1, start=0, last=0, sew_out=00, all mult_out=0000.
- 32-bit op: sew=10, A=B=FFFFFFFF -> two consecutive beats, all 8 lanes=FE01 each; last=0 then 1; in_ready=0 during beat 0; then idle with outputs 0.
- 16-bit op: sew=01, A=01020304, B=05060708 -> single beat 0020,0018,001C,0015,000C,0006,000A,0005; last=1.
- 8-bit back-to-back: in_valid held 1 with sew=00, A=04030201 B=05050505 then A=FFFFFFFF B=02020202 -> consecutive beats 0005,000A,000F,0014,0,0,0,0 then 01FE x4, 0 x4; no idle gap.
- Reset mid-op: sew=10 accepted, reset=0 during BEAT0 -> outputs zero immediately; after release no beat 1 appears; state IDLE.
- Illegal sew: sew=11, any operands -> one beat, all lanes 0, start=1, last=1, sew_out=11.

Source files
------------

// File: rtl/mult_pp_issue_8.sv
// ---------------------------------------------------------------------------
// mult_pp_issue_8
//   Partial-product issue stage that feeds the carry-save accumulator of the
//   8-bit multiplier unit. Accepts a 32-bit operand pair plus element width
//   over valid/ready. It splits the operands into bytes and presents eight
//   unsigned 8x8 products per beat on mult_out_1..8, together with start,
//   sew_out and last.
//     sew=00 (8b)  : one beat, diagonal byte products
//     sew=01 (16b) : one beat, the four products of each 16-bit half
//     sew=10 (32b) : two beats, columns b0/b1 then columns b2/b3
//     sew=11       : one all-zero beat tagged 11 so downstream flags it
// ---------------------------------------------------------------------------
module mult_pp_issue_8 (
    input  logic        clk,
    input  logic        reset,      // asynchronous, active-low
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  sew,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        start,
    output logic [1:0]  sew_out,
    output logic        last,
    output logic [15:0] mult_out_1,
    output logic [15:0] mult_out_2,
    output logic [15:0] mult_out_3,
    output logic [15:0] mult_out_4,
    output logic [15:0] mult_out_5,
    output logic [15:0] mult_out_6,
    output logic [15:0] mult_out_7,
    output logic [15:0] mult_out_8
);

    // Element-width encodings
    localparam logic [1:0] SEW_8   = 2'b00;
    localparam logic [1:0] SEW_16  = 2'b01;
    localparam logic [1:0] SEW_32  = 2'b10;
    localparam logic [1:0] SEW_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10
    } state_t;

    // Eight 16-bit product lanes; lane 0 drives mult_out_1
    typedef logic [7:0][15:0] lanes_t;

    // Unsigned byte product, zero-extended to the 16-bit lane width
    function automatic logic [15:0] f_mul(input logic [7:0] x, input logic [7:0] y);
        return {8'h00, x} * {8'h00, y};
    endfunction

    // Product lanes for one beat of an operation.
    // beat1 only matters for 32-bit elements, which need two beats.
    function automatic lanes_t f_beat(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [1:0]  s,
        input logic        beat1
    );
        logic [3:0][7:0] av;
        logic [3:0][7:0] bv;
        logic [7:0]      b_lo;
        logic [7:0]      b_hi;
        lanes_t          l;
        av   = a;
        bv   = b;
        b_lo = beat1 ? bv[2] : bv[0];
        b_hi = beat1 ? bv[3] : bv[1];
        l    = '0;
        case (s)
            SEW_32: begin
                // One column of B per half: every A byte times b_lo / b_hi
                l[0] = f_mul(av[0], b_lo);
                l[1] = f_mul(av[1], b_lo);
                l[2] = f_mul(av[2], b_lo);
                l[3] = f_mul(av[3], b_lo);
                l[4] = f_mul(av[0], b_hi);
                l[5] = f_mul(av[1], b_hi);
                l[6] = f_mul(av[2], b_hi);
                l[7] = f_mul(av[3], b_hi);
            end
            SEW_16: begin
                // Lower halfword in lanes 0-3, upper halfword in lanes 4-7
                l[0] = f_mul(av[0], bv[0]);
                l[1] = f_mul(av[1], bv[0]);
                l[2] = f_mul(av[0], bv[1]);
                l[3] = f_mul(av[1], bv[1]);
                l[4] = f_mul(av[2], bv[2]);
                l[5] = f_mul(av[3], bv[2]);
                l[6] = f_mul(av[2], bv[3]);
                l[7] = f_mul(av[3], bv[3]);
            end
            SEW_8: begin
                // Each byte element multiplies only its own partner
                l[0] = f_mul(av[0], bv[0]);
                l[1] = f_mul(av[1], bv[1]);
                l[2] = f_mul(av[2], bv[2]);
                l[3] = f_mul(av[3], bv[3]);
            end
            default: begin
                // SEW_ILL: lanes stay zero, the tag on sew_out carries the error
                l = '0;
            end
        endcase
        return l;
    endfunction

    // -----------------------------------------------------------------------
    // State and registers
    // -----------------------------------------------------------------------
    state_t      r_state;
    logic [1:0]  r_sew_q;
    logic [31:0] r_a_q;
    logic [31:0] r_b_q;
    lanes_t      r_lanes;
    logic        r_start;
    logic        r_last;
    logic [1:0]  r_sew_out;

    state_t      w_state_nxt;
    lanes_t      w_lanes_nxt;
    logic        w_start_nxt;
    logic        w_last_nxt;
    logic [1:0]  w_sew_out_nxt;
    logic        w_accept;
    logic        w_beat1_due;

    // A 32-bit op in BEAT0 still owes its second beat, so it blocks new work.
    // Every other state either is idle or is presenting its final beat.
    assign in_ready = (r_state == ST_IDLE)
                    | ((r_state == ST_BEAT0) & (r_sew_q != SEW_32))
                    | (r_state == ST_BEAT1);

    assign w_accept    = in_valid & in_ready;
    assign w_beat1_due = (r_state == ST_BEAT0) & (r_sew_q == SEW_32);

    // Next-state and next-beat selection: pending beat 1 first, else a new
    // accept's beat 0 (back-to-back with no bubble), else drop to idle.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        w_state_nxt   = ST_IDLE;
        w_lanes_nxt   = '0;
        w_start_nxt   = 1'b0;
        w_last_nxt    = 1'b0;
        w_sew_out_nxt = SEW_8;
        if (w_beat1_due) begin
            w_state_nxt   = ST_BEAT1;
            w_lanes_nxt   = f_beat(r_a_q, r_b_q, r_sew_q, 1'b1);
            w_start_nxt   = 1'b1;
            w_last_nxt    = 1'b1;
            w_sew_out_nxt = r_sew_q;
        end else if (w_accept) begin
            w_state_nxt   = ST_BEAT0;
            w_lanes_nxt   = f_beat(op_a, op_b, sew, 1'b0);
            w_start_nxt   = 1'b1;
            w_last_nxt    = (sew != SEW_32);
            w_sew_out_nxt = sew;
        end
    end

    // State register; reset returns to IDLE and abandons any pending beat
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so all registers update
        // together at the edge, independent of statement order.
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch: captured on accept so input changes mid-op are ignored
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the operand copies are reset as well; they are only read in
        // BEAT0, but a defined value keeps simulation X-free after reset.
        if (!reset) begin
            r_sew_q <= SEW_8;
            r_a_q   <= '0;
            r_b_q   <= '0;
        end else if (w_accept) begin
            r_sew_q <= sew;
            r_a_q   <= op_a;
            r_b_q   <= op_b;
        end
    end

    // Output beat registers: load every edge with the selected beat (or zero)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lanes   <= '0;
            r_start   <= 1'b0;
            r_last    <= 1'b0;
            r_sew_out <= SEW_8;
        end else begin
            r_lanes   <= w_lanes_nxt;
            r_start   <= w_start_nxt;
            r_last    <= w_last_nxt;
            r_sew_out <= w_sew_out_nxt;
        end
    end

    assign start      = r_start;
    assign last       = r_last;
    assign sew_out    = r_sew_out;
    assign mult_out_1 = r_lanes[0];
    assign mult_out_2 = r_lanes[1];
    assign mult_out_3 = r_lanes[2];
    assign mult_out_4 = r_lanes[3];
    assign mult_out_5 = r_lanes[4];
    assign mult_out_6 = r_lanes[5];
    assign mult_out_7 = r_lanes[6];
    assign mult_out_8 = r_lanes[7];

endmodule

// File: tb/tb_mult_pp_issue_8.sv
// ---------------------------------------------------------------------------
// tb_mult_pp_issue_8
//   Directed scenarios with literal expectations, followed by randomized
//   traffic checked every cycle against a beat-queue reference model.
// ---------------------------------------------------------------------------
module tb_mult_pp_issue_8;

    typedef logic [7:0][15:0] lanes_t;

    typedef struct {
        lanes_t     lanes;
        logic [1:0] sew;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sew;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        start;
    logic [1:0]  sew_out;
    logic        last;
    logic [15:0] mult_out_1, mult_out_2, mult_out_3, mult_out_4;
    logic [15:0] mult_out_5, mult_out_6, mult_out_7, mult_out_8;

    int n_tests = 0;
    int n_fail  = 0;

    mult_pp_issue_8 dut (
        .clk        (clk),
        .reset      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sew        (sew),
        .op_a       (op_a),
        .op_b       (op_b),
        .start      (start),
        .sew_out    (sew_out),
        .last       (last),
        .mult_out_1 (mult_out_1),
        .mult_out_2 (mult_out_2),
        .mult_out_3 (mult_out_3),
        .mult_out_4 (mult_out_4),
        .mult_out_5 (mult_out_5),
        .mult_out_6 (mult_out_6),
        .mult_out_7 (mult_out_7),
        .mult_out_8 (mult_out_8)
    );

    always #5 clk = ~clk;

    lanes_t dut_lanes;
    assign dut_lanes = {mult_out_8, mult_out_7, mult_out_6, mult_out_5,
                        mult_out_4, mult_out_3, mult_out_2, mult_out_1};

    // {start, last, sew_out, in_ready}
    logic [4:0] dut_ctrl;
    assign dut_ctrl = {start, last, sew_out, in_ready};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected lanes straight from the byte-pairing tables
    function automatic lanes_t exp_beat(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] s, input int beat);
        int av[4];
        int bv[4];
        int ai16[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
        int bi16[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        lanes_t l = '0;
        for (int k = 0; k < 4; k++) begin
            av[k] = int'(a[8*k +: 8]);
            bv[k] = int'(b[8*k +: 8]);
        end
        case (s)
            2'b10: for (int i = 0; i < 4; i++) begin
                l[i]   = 16'(av[i] * bv[2*beat]);
                l[i+4] = 16'(av[i] * bv[2*beat+1]);
            end
            2'b01: for (int i = 0; i < 8; i++) l[i] = 16'(av[ai16[i]] * bv[bi16[i]]);
            2'b00: for (int i = 0; i < 4; i++) l[i] = 16'(av[i] * bv[i]);
            default: l = '0;
        endcase
        return l;
    endfunction

    // Reference model: the beat on display plus a queue of beats still owed.
    // The block is ready whenever nothing is owed.
    beat_t mq[$];
    beat_t m_cur;
    bit    m_cur_v = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cur_v = 1'b0;
        end else begin
            if (mq.size() > 0) begin
                m_cur   = mq.pop_front();
                m_cur_v = 1'b1;
            end else if (in_valid) begin
                m_cur   = '{lanes: exp_beat(op_a, op_b, sew, 0), sew: sew, last: (sew != 2'b10)};
                m_cur_v = 1'b1;
                if (sew == 2'b10)
                    mq.push_back('{lanes: exp_beat(op_a, op_b, sew, 1), sew: sew, last: 1'b1});
            end else begin
                m_cur_v = 1'b0;
            end
            #1;
            if (m_cur_v) begin
                check("model_lanes", 128'(dut_lanes), 128'(m_cur.lanes));
                check("model_ctrl", 128'(dut_ctrl),
                      128'({1'b1, m_cur.last, m_cur.sew, mq.size() == 0}));
            end else begin
                check("model_lanes", 128'(dut_lanes), 128'(0));
                check("model_ctrl", 128'(dut_ctrl), 128'(5'b0_0_00_1));
            end
        end
    end

    task automatic set_op(input logic v, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        sew      = s;
        op_a     = a;
        op_b     = b;
    endtask

    initial begin
        rst_n = 1'b0;
        set_op(1'b0, 2'b00, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_lanes", 128'(dut_lanes), 128'(0));
        check("rst_ctrl", 128'(dut_ctrl), 128'(5'b0_0_00_1));
        rst_n = 1'b1;
        @(negedge clk);

        // 32-bit op: two beats, inputs scrambled after accept
        set_op(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        set_op(1'b0, 2'b00, 32'h0, 32'h0);
        check("w32_b0_lanes", 128'(dut_lanes), {8{16'hFE01}});
        check("w32_b0_ctrl", 128'(dut_ctrl), 128'(5'b1_0_10_0));
        @(negedge clk);
        check("w32_b1_lanes", 128'(dut_lanes), {8{16'hFE01}});
        check("w32_b1_ctrl", 128'(dut_ctrl), 128'(5'b1_1_10_1));
        @(negedge clk);
        check("w32_idle_lanes", 128'(dut_lanes), 128'(0));
        check("w32_idle_ctrl", 128'(dut_ctrl), 128'(5'b0_0_00_1));

        // 16-bit op: single beat
        set_op(1'b1, 2'b01, 32'h0102_0304, 32'h0506_0708);
        @(negedge clk);
        set_op(1'b0, 2'b00, 32'h0, 32'h0);
        check("w16_lanes", 128'(dut_lanes),
              {16'h0005, 16'h000A, 16'h0006, 16'h000C, 16'h0015, 16'h001C, 16'h0018, 16'h0020});
        check("w16_ctrl", 128'(dut_ctrl), 128'(5'b1_1_01_1));
        @(negedge clk);
        check("w16_idle_ctrl", 128'(dut_ctrl), 128'(5'b0_0_00_1));

        // 8-bit back-to-back: no idle gap
        set_op(1'b1, 2'b00, 32'h0403_0201, 32'h0505_0505);
        @(negedge clk);
        set_op(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0202_0202);
        check("w8a_lanes", 128'(dut_lanes),
              {16'h0, 16'h0, 16'h0, 16'h0, 16'h0014, 16'h000F, 16'h000A, 16'h0005});
        check("w8a_ctrl", 128'(dut_ctrl), 128'(5'b1_1_00_1));
        @(negedge clk);
        set_op(1'b0, 2'b00, 32'h0, 32'h0);
        check("w8b_lanes", 128'(dut_lanes),
              {16'h0, 16'h0, 16'h0, 16'h0, 16'h01FE, 16'h01FE, 16'h01FE, 16'h01FE});
        check("w8b_ctrl", 128'(dut_ctrl), 128'(5'b1_1_00_1));
        @(negedge clk);
        check("w8_idle_ctrl", 128'(dut_ctrl), 128'(5'b0_0_00_1));

        // Illegal sew: zero lanes, tagged 11
        set_op(1'b1, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        set_op(1'b0, 2'b00, 32'h0, 32'h0);
        check("ill_lanes", 128'(dut_lanes), 128'(0));
        check("ill_ctrl", 128'(dut_ctrl), 128'(5'b1_1_11_1));
        @(negedge clk);

        // Reset in BEAT0 of a 32-bit op: immediate clear, beat 1 never shows
        set_op(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        set_op(1'b0, 2'b00, 32'h0, 32'h0);
        check("rmid_b0_ctrl", 128'(dut_ctrl), 128'(5'b1_0_10_0));
        #2 rst_n = 1'b0;
        #1;
        check("rmid_async_lanes", 128'(dut_lanes), 128'(0));
        check("rmid_async_ctrl", 128'(dut_ctrl), 128'(5'b0_0_00_1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rmid_after_lanes", 128'(dut_lanes), 128'(0));
        check("rmid_after_ctrl", 128'(dut_ctrl), 128'(5'b0_0_00_1));
        @(negedge clk);
        check("rmid_after2_ctrl", 128'(dut_ctrl), 128'(5'b0_0_00_1));

        // Randomized traffic against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            in_valid = ($urandom_range(0, 9) < 7);
            sew      = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
                0:       op_a = 32'hFFFF_FFFF;
                1:       op_a = 32'h0;
                default: op_a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       op_b = 32'hFFFF_FFFF;
                1:       op_b = 32'h0;
                default: op_b = $urandom;
            endcase
            @(negedge clk);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
